// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the memory-op stage.
// Fetch does one read per grant; a data grant carries up to two RAM micro-ops
// (slot 1 then slot 2), each waiting for ram_ack. A bounded data-priority
// streak keeps fetch from starving while both sides request.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_op1,
  input  logic [1:0]        d_op2,
  input  logic [ADDR_W-1:0] d_addr1,
  input  logic [ADDR_W-1:0] d_addr2,
  input  logic [DATA_W-1:0] d_wdata1,
  input  logic [DATA_W-1:0] d_wdata2,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata1,
  output logic [DATA_W-1:0] d_rdata2,
  output logic              d_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_r,
  output logic              ram_w,
  output logic [DATA_W-1:0] ram_w_line,
  input  logic [DATA_W-1:0] ram_r_line,
  input  logic              ram_ack
);

  typedef enum logic [2:0] {S_IDLE, S_F_ACC, S_D1, S_D2, S_FIN} state_t;

  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [3:0] STARVE_L = 4'(STARVE);

  state_t            r_state;
  logic [3:0]        r_streak;
  logic              r_f_gnt, r_f_done, r_d_gnt, r_d_done;
  logic              r_ram_r, r_ram_w;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_w_line;
  logic [DATA_W-1:0] r_f_rdata, r_d_rdata1, r_d_rdata2;

  // Slot fields held for the duration of a data transaction; slot 1 is
  // issued straight from the request inputs at the grant edge, so only the
  // slot-1 op code is needed afterwards (to route the read result).
  logic [1:0]        r_op1, r_op2;
  logic [ADDR_W-1:0] r_addr2;
  logic [DATA_W-1:0] r_wdata2;

  logic w_strobe, w_ack, w_turn, w_gnt_d, w_gnt_f;

  // Reserved op code 11 behaves like "none".
  function automatic logic op_active(input logic [1:0] op);
    return (op == OP_RD) || (op == OP_WR);
  endfunction

  function automatic logic [3:0] streak_inc(input logic [3:0] s);
    return (s >= STARVE_L) ? STARVE_L : s + 4'd1;
  endfunction

  assign w_strobe = r_ram_r | r_ram_w;
  assign w_ack    = ram_ack & w_strobe;
  // A done pulse in flight forces one idle arbitration cycle before any grant.
  assign w_turn   = r_f_done | r_d_done;
  assign w_gnt_d  = (r_state == S_IDLE) & ~w_turn & d_req &
                    (~f_req | (r_streak != STARVE_L));
  assign w_gnt_f  = (r_state == S_IDLE) & ~w_turn & f_req & ~w_gnt_d;

  assign f_gnt      = r_f_gnt;
  assign f_done     = r_f_done;
  assign f_rdata    = r_f_rdata;
  assign d_gnt      = r_d_gnt;
  assign d_done     = r_d_done;
  assign d_rdata1   = r_d_rdata1;
  assign d_rdata2   = r_d_rdata2;
  assign d_stall    = d_req & ~r_d_done;
  assign ram_addr   = r_ram_addr;
  assign ram_r      = r_ram_r;
  assign ram_w      = r_ram_w;
  assign ram_w_line = r_ram_w_line;

  // Capture the data request's slot fields at the data grant edge.
  always_ff @(posedge clk) begin
    if (w_gnt_d) begin
      r_op1    <= d_op1;
      r_op2    <= d_op2;
      r_addr2  <= d_addr2;
      r_wdata2 <= d_wdata2;
    end
  end

  // Arbitration FSM driving grants, dones, RAM strobes and read results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_streak     <= 4'd0;
      r_f_gnt      <= 1'b0;
      r_f_done     <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_d_done     <= 1'b0;
      r_ram_r      <= 1'b0;
      r_ram_w      <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_w_line <= '0;
      r_f_rdata    <= '0;
      r_d_rdata1   <= '0;
      r_d_rdata2   <= '0;
    end else begin
      r_f_gnt  <= 1'b0;
      r_f_done <= 1'b0;
      r_d_gnt  <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_d) begin
            r_d_gnt  <= 1'b1;
            r_streak <= f_req ? streak_inc(r_streak) : 4'd0;
            if (op_active(d_op1)) begin
              r_state    <= S_D1;
              r_ram_r    <= (d_op1 == OP_RD);
              r_ram_w    <= (d_op1 == OP_WR);
              r_ram_addr <= d_addr1;
              if (d_op1 == OP_WR) r_ram_w_line <= d_wdata1;
            end else if (op_active(d_op2)) begin
              r_state    <= S_D2;
              r_ram_r    <= (d_op2 == OP_RD);
              r_ram_w    <= (d_op2 == OP_WR);
              r_ram_addr <= d_addr2;
              if (d_op2 == OP_WR) r_ram_w_line <= d_wdata2;
            end else begin
              r_state <= S_FIN;
            end
          end else if (w_gnt_f) begin
            r_f_gnt    <= 1'b1;
            r_streak   <= 4'd0;
            r_ram_r    <= 1'b1;
            r_ram_addr <= f_addr;
            r_state    <= S_F_ACC;
          end
        end
        S_F_ACC: begin
          if (w_ack) begin
            r_f_rdata <= ram_r_line;
            r_f_done  <= 1'b1;
            r_ram_r   <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_D1: begin
          if (w_ack) begin
            if (r_op1 == OP_RD) r_d_rdata1 <= ram_r_line;
            r_ram_r <= 1'b0;
            r_ram_w <= 1'b0;
            r_state <= op_active(r_op2) ? S_D2 : S_FIN;
          end
        end
        S_D2: begin
          // Arriving from D1 the strobe is low: that cycle is the bubble,
          // and slot 2 is issued at its closing edge.
          if (!w_strobe) begin
            r_ram_r    <= (r_op2 == OP_RD);
            r_ram_w    <= (r_op2 == OP_WR);
            r_ram_addr <= r_addr2;
            if (r_op2 == OP_WR) r_ram_w_line <= r_wdata2;
          end else if (w_ack) begin
            if (r_op2 == OP_RD) r_d_rdata2 <= ram_r_line;
            r_ram_r <= 1'b0;
            r_ram_w <= 1'b0;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_d_done <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus, behavioural RAM with
// programmable ack delay, and a scoreboard of expected completions.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt, f_done;
  logic [31:0] f_rdata;
  logic        d_req;
  logic [1:0]  d_op1, d_op2;
  logic [31:0] d_addr1, d_addr2, d_wdata1, d_wdata2;
  logic        d_gnt, d_done, d_stall;
  logic [31:0] d_rdata1, d_rdata2;
  logic [31:0] ram_addr, ram_w_line, ram_r_line;
  logic        ram_r, ram_w, ram_ack;

  int ack_delay;
  bit force_ack;
  int n_tests;
  int n_fail;
  int gnt_cnt;
  logic [15:0] gl_bits;
  logic [31:0] mem [logic [31:0]];

  typedef struct {
    bit          is_f;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;
  exp_t sb[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done),
    .f_rdata(f_rdata),
    .d_req(d_req), .d_op1(d_op1), .d_op2(d_op2), .d_addr1(d_addr1),
    .d_addr2(d_addr2), .d_wdata1(d_wdata1), .d_wdata2(d_wdata2),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata1(d_rdata1), .d_rdata2(d_rdata2),
    .d_stall(d_stall),
    .ram_addr(ram_addr), .ram_r(ram_r), .ram_w(ram_w), .ram_w_line(ram_w_line),
    .ram_r_line(ram_r_line), .ram_ack(ram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_f, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.is_f = is_f;
    e.r1   = r1;
    e.r2   = r2;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural RAM: acks after ack_delay extra strobe cycles.
  initial begin
    int cnt;
    cnt = 0;
    ram_ack = 1'b0;
    ram_r_line = 32'h0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h24]  = 32'h22222222;
    forever begin
      @(negedge clk);
      if (ram_r || ram_w) begin
        if (cnt >= ack_delay) begin
          ram_ack = 1'b1;
          if (ram_r) ram_r_line = mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
          if (ram_w) mem[ram_addr] = ram_w_line;
          cnt = 0;
        end else begin
          ram_ack = force_ack;
          cnt++;
        end
      end else begin
        ram_ack = force_ack;
        cnt = 0;
      end
    end
  end

  // Monitor: logs grant order and checks each completion against the scoreboard.
  initial begin
    exp_t e;
    gnt_cnt = 0;
    gl_bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (f_gnt || d_gnt) begin
          gl_bits = {gl_bits[14:0], f_gnt};
          gnt_cnt++;
        end
        if (f_done || d_done) begin
          chk("sb_has_entry", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            if (f_done) begin
              chk("sb_kind_f", e.is_f, 1);
              chk("sb_f_rdata", f_rdata, e.r1);
            end else begin
              chk("sb_kind_d", e.is_f, 0);
              chk("sb_d_rdata1", d_rdata1, e.r1);
              chk("sb_d_rdata2", d_rdata2, e.r2);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    logic [17:0] trace;
    logic [8:0]  donev;
    logic [1:0]  acc;
    int g0;
    bit ok;
    n_tests = 0; n_fail = 0;
    ack_delay = 0; force_ack = 1'b0;
    rst = 1'b0; f_req = 1'b0; f_addr = '0; d_req = 1'b0;
    d_op1 = 2'b00; d_op2 = 2'b00; d_addr1 = '0; d_addr2 = '0;
    d_wdata1 = '0; d_wdata2 = '0;
    step(); step(); step();
    chk("rst_ctrl", {f_gnt, d_gnt, f_done, d_done, ram_r, ram_w}, 0);
    chk("rst_data", {ram_addr, ram_w_line, f_rdata, d_rdata1, d_rdata2}, 0);
    rst = 1'b1;
    step();

    // Fetch only, immediate ack.
    f_req = 1'b1; f_addr = 32'h100;
    push_exp(1'b1, 32'hDEADBEEF, 32'h0);
    step();
    chk("fetch_gnt", {f_gnt, ram_r, ram_w}, 3'b110);
    chk("fetch_addr", ram_addr, 32'h100);
    f_req = 1'b0;
    step();
    chk("fetch_done", {f_done, ram_r}, 2'b10);
    step();

    // Data: slot 1 read only, best case latency 2.
    d_req = 1'b1; d_op1 = 2'b01; d_addr1 = 32'h100; d_op2 = 2'b00;
    push_exp(1'b0, 32'hDEADBEEF, 32'h0);
    step();
    chk("d1rd_gnt", {d_gnt, ram_r}, 2'b11);
    step();
    chk("d1rd_fin", {d_done, ram_r}, 2'b00);
    step();
    chk("d1rd_done", d_done, 1);
    d_req = 1'b0;
    step();

    // Data: write slot 1, read slot 2, ack delayed 2 cycles each.
    ack_delay = 2;
    d_req = 1'b1; d_op1 = 2'b10; d_addr1 = 32'h20; d_wdata1 = 32'h11111111;
    d_op2 = 2'b01; d_addr2 = 32'h24;
    push_exp(1'b0, 32'hDEADBEEF, 32'h22222222);
    trace = '0; donev = '0;
    for (int i = 0; i < 9; i++) begin
      step();
      trace = {trace[15:0], ram_w, ram_r};
      donev = {donev[7:0], d_done};
      if (i == 0) begin
        chk("wr_gnt", {d_gnt, d_stall}, 2'b11);
        chk("wr_addr", ram_addr, 32'h20);
        chk("wr_line", ram_w_line, 32'h11111111);
      end
      if (i == 4) chk("rd2_addr", ram_addr, 32'h24);
      if (i == 8) begin
        chk("wr_stall_done", d_stall, 0);
        d_req = 1'b0;
      end
    end
    chk("wr_rd_trace", trace, 18'b10_10_10_00_01_01_01_00_00);
    chk("wr_rd_done_at", donev, 9'b000000001);
    chk("ram_written", mem[32'h20], 32'h11111111);
    ack_delay = 0;
    step();
    chk("w_line_hold", ram_w_line, 32'h11111111);

    // Reserved/none ops: no RAM access, done one cycle after grant.
    d_req = 1'b1; d_op1 = 2'b11; d_op2 = 2'b00;
    push_exp(1'b0, 32'hDEADBEEF, 32'h22222222);
    step();
    chk("none_gnt", {d_gnt, ram_r, ram_w, d_stall}, 4'b1001);
    step();
    chk("none_done", {d_done, ram_r, ram_w, d_stall}, 4'b1000);
    d_req = 1'b0;
    step();

    // Simultaneous first requests: data first, fetch after turnaround.
    f_addr = 32'h100; f_req = 1'b1; d_req = 1'b1; d_op1 = 2'b00; d_op2 = 2'b00;
    push_exp(1'b0, 32'hDEADBEEF, 32'h22222222);
    push_exp(1'b1, 32'hDEADBEEF, 32'h0);
    step();
    chk("sim_dgnt", {d_gnt, f_gnt}, 2'b10);
    step();
    chk("sim_ddone", d_done, 1);
    d_req = 1'b0;
    step();
    chk("sim_turn", f_gnt, 0);
    chk("sim_streak", dut.r_streak, 1);
    step();
    chk("sim_fgnt", f_gnt, 1);
    f_req = 1'b0;
    step();
    step();

    // Both held: STARVE=4 gives D,D,D,D,F,D,D,D,D,F.
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) push_exp(1'b1, 32'hDEADBEEF, 32'h0);
      else push_exp(1'b0, 32'hDEADBEEF, 32'h22222222);
    end
    g0 = gnt_cnt;
    f_req = 1'b1; d_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (gnt_cnt - g0 >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    chk("starve_complete", ok, 1);
    chk("starve_order", gl_bits[9:0], 10'b0000100001);
    step(); step(); step();
    chk("sb_drained", sb.size(), 0);

    // Reset in the middle of a slot-1 write.
    ack_delay = 5;
    d_req = 1'b1; d_op1 = 2'b10; d_addr1 = 32'h40; d_wdata1 = 32'h33333333;
    d_op2 = 2'b00;
    step();
    chk("mid_w_high", {d_gnt, ram_w}, 2'b11);
    d_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {f_gnt, d_gnt, f_done, d_done, ram_r, ram_w}, 0);
    chk("mid_rst_data", {ram_addr, ram_w_line, f_rdata, d_rdata1, d_rdata2}, 0);
    step();
    rst = 1'b1;
    ack_delay = 0;
    force_ack = 1'b1;
    acc = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      acc = acc | {(f_done | d_done), (ram_r | ram_w | f_gnt | d_gnt)};
    end
    force_ack = 1'b0;
    chk("stray_ack_quiet", acc, 2'b00);
    step();
    chk("sb_final_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port RAM arbiter between the instruction-fetch requester and the memory-op stage. Grants one requester at a time and drives the shared RAM strobes, address and write lane. Serializes the up-to-two RAM micro-ops a data instruction can carry (slot 1 then slot 2), waiting on a RAM acknowledge for each. Fetch is protected from starvation by a bounded data-priority streak.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `STARVE`, 4: maximum consecutive data grants while fetch is waiting; range 1-15.

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `f_req` input 1: fetch request; level.
- `f_addr` input ADDR_W: fetch address.
- `f_gnt` output 1: one-cycle pulse; fetch fields latched.
- `f_done` output 1: one-cycle pulse; `f_rdata` valid.
- `f_rdata` output DATA_W: fetched word.
- `d_req` input 1: data request; level.
- `d_op1`, `d_op2` input 2 each: 00 none, 01 read, 10 write, 11 reserved (treated as none).
- `d_addr1`, `d_addr2` input ADDR_W: slot addresses.
- `d_wdata1`, `d_wdata2` input DATA_W: slot write data.
- `d_gnt` output 1: one-cycle pulse; data fields latched.
- `d_done` output 1: one-cycle pulse; read results valid.
- `d_rdata1`, `d_rdata2` output DATA_W: slot read results.
- `d_stall` output 1: combinational `d_req & ~d_done`.
- `ram_addr` output ADDR_W: RAM address (registered).
- `ram_r`, `ram_w` output 1: RAM strobes (registered); never both high.
- `ram_w_line` output DATA_W: RAM write data (registered).
- `ram_r_line` input DATA_W: RAM read data; valid with `ram_ack`.
- `ram_ack` input 1: access complete; sampled only while a strobe is high.

## Operation
- States: IDLE, F_ACC, D1, D2, FIN.
- IDLE, arbitration:
  - No grant in a cycle where `f_done` or `d_done` is high (turnaround).
  - Only one requester: grant it.
  - Both requesting: data wins unless `streak == STARVE`; then fetch wins.
- `streak`: 4-bit counter.
  - Increments on each data grant made while `f_req` is high; saturates at STARVE.
  - Clears on fetch grant, and on a data grant while `f_req` is low.
- Fetch grant: pulse `f_gnt`, latch `f_addr`, go F_ACC.
  - F_ACC: `ram_r=1`, `ram_addr` = latched address.
  - On ack: capture `ram_r_line` into `f_rdata`, pulse `f_done`, drop strobe, go IDLE.
- Data grant: pulse `d_gnt`, latch all slot fields.
  - Slot 1 active: go D1. Else slot 2 active: go D2. Else (both none): go FIN, no RAM access.
  - D1 / D2 issue the slot op: read → `ram_r=1`; write → `ram_w=1`, `ram_w_line` = slot wdata.
  - On ack in D1: go D2 if slot 2 active, else FIN.
  - On ack in D2: go FIN.
  - Read slot on ack: capture `ram_r_line` into `d_rdataN`.
  - Write slot, or a slot with op none: `d_rdataN` keeps its previous value.
- FIN: pulse `d_done`, go IDLE.
- Slot order is fixed: slot 1 always completes before slot 2 starts.
- `ram_addr` and `ram_w_line` hold their last value when no strobe is high.

## Timing
- Reset (`rst` low, asynchronous):
  - State IDLE; `streak` = 0.
  - All outputs 0: strobes, grants, dones, `ram_addr`, `ram_w_line`, all rdata.
  - Any in-flight access is abandoned; a late `ram_ack` after reset release is ignored.
- Grant decided at edge E. The grant pulse and strobe rise together in cycle E+1.
- Strobe stays high until the cycle in which `ram_ack` is sampled high (minimum 1 cycle).
- Strobe is low in the cycle after the ack. Between slots 1 and 2 there is exactly one bubble cycle.
- Fetch latency: `f_done` rises one cycle after the ack cycle. Best case: `f_gnt` in cycle 1, `f_done` in cycle 2.
- Data latency, best case (ack same cycle as strobe):
  - Two slots: `d_done` 4 cycles after grant edge.
  - One slot: 2 cycles.
  - No slots: 1 cycle.
- Requesters must drop or renew req in the done cycle. Request inputs after the grant pulse are don't-care.
- Simultaneous `f_req`/`d_req` rising in the same cycle: priority rule applies; the loser waits in IDLE with req held.
- Turnaround: the cycle after a done pulse is an arbitration cycle, so back-to-back grants are separated by at least one cycle.

## Test plan
- Fetch only, `f_addr=0x100`, ack on first strobe cycle, RAM returns `0xDEADBEEF` → `f_gnt` cycle 1, `ram_r` cycle 1, `f_done` cycle 2 with `f_rdata=0xDEADBEEF`.
- Data: op1 write `0x20`/`0x11111111`, op2 read `0x24`, RAM returns `0x22222222`, ack delayed 2 cycles each → `ram_w` then bubble then `ram_r`; `d_done` with `d_rdata2=0x22222222`; `d_rdata1` unchanged.
- `d_op1=11`, `d_op2=00` → no strobes; `d_done` 1 cycle after grant; `d_stall` high until `d_done`.
- `f_req` and `d_req` held continuously, STARVE=4 → grant order D,D,D,D,F,D,D,D,D,F.
- `rst` low mid D1 with `ram_w` high → all outputs 0 immediately. After release with `d_req=0`: remains IDLE; a stray `ram_ack` produces no done.
- Simultaneous first requests, `streak=0` → `d_gnt` first. `f_gnt` after `d_done` plus one turnaround cycle; `streak=1` at that point.
